sn_encoder: RTL



---
 rtl/sn_encoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/sn_encoder.sv
// Binary-to-stochastic encoder: four bipolar 4-bit lanes compared against a 16-state de Bruijn source.
// Optional macro SN_ENCODER_DECORR_EN rotates the random value per lane to decorrelate streams.
module sn_encoder #(
    parameter int unsigned     LANES  = 4,
    parameter int unsigned     DATA_W = 4,
    parameter logic [DATA_W-1:0] SEED = 4'b0001
) (
    input  logic              i_clk_sng,
    input  logic              i_rst_n_sng,
    input  logic              i_start_sng,
    input  logic              i_stop_sng,
    input  logic [DATA_W-1:0] i_x_sng [LANES-1:0],
    input  logic [DATA_W-1:0] i_len_sng,
    output logic              o_busy_sng,
    output logic              o_valid_sng,
    output logic              o_done_sng,
    output logic              o_sn_bit [LANES-1:0]
);

    typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] x_q [LANES-1:0];
    logic [DATA_W-1:0] x_d [LANES-1:0];
    logic [DATA_W-1:0] r_next;

    // Extra term on r[2:0]==0 splices the all-zero state into the 15-state LFSR cycle.
    assign r_next = {r_q[2:0], r_q[3] ^ r_q[2] ^ (r_q[2:0] == 3'b000)};

    always_ff @(posedge i_clk_sng or negedge i_rst_n_sng) begin
        if (!i_rst_n_sng) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= SEED;
            len_q   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            len_q   <= len_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        len_d   = len_q;
        x_d     = x_q;
        unique case (state_q)
            StIdle, StDone: begin
                // Stop wins over start when both arrive outside a frame.
                if (i_start_sng && !i_stop_sng) begin
                    state_d = StGen;
                    x_d     = i_x_sng;
                    len_d   = i_len_sng;
                    r_d     = SEED;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StGen: begin
                if (i_stop_sng) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    r_d     = SEED;
                end else begin
                    r_d   = r_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy_sng  = (state_q == StGen);
        o_valid_sng = (state_q == StGen);
        o_done_sng  = (state_q == StDone);
        for (int i = 0; i < int'(LANES); i++) begin
            logic [DATA_W-1:0] u;
            logic [DATA_W-1:0] r_lane;
            u = x_q[i] ^ {1'b1, {(DATA_W-1){1'b0}}};
`ifdef SN_ENCODER_DECORR_EN
            r_lane = (r_q << (i % int'(DATA_W))) | (r_q >> ((int'(DATA_W) - (i % int'(DATA_W))) % int'(DATA_W)));
`else
            r_lane = r_q;
`endif
            o_sn_bit[i] = (state_q == StGen) && (u > r_lane);
        end
    end

endmodule
